// File: rtl/writeback_stage_vp_pkg.sv
// Shared types and constants for the vector-pipeline writeback stage.
// Optional forwarding outputs are enabled by defining WB_FORWARD_EN.
package vp_wb_pkg;
    localparam int DEF_LANES      = 4;
    localparam int DEF_LANE_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int PC_WIDTH       = 32;

    typedef enum logic [1:0] {
        RS_ALU = 2'b00,
        RS_MEM = 2'b01,
        RS_PC4 = 2'b10
    } result_source_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } wb_state_t;

    // Lane index width; a single-lane build still needs a 1-bit field.
    function automatic int idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction
endpackage

// File: rtl/writeback_stage_vp_if.sv
// Pipe-register inputs and register-file write outputs of the writeback stage.
// Forwarding signals exist only when WB_FORWARD_EN is defined.
interface writeback_stage_vp_if #(
    parameter int LANES      = 4,
    parameter int LANE_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    import vp_wb_pkg::*;
    localparam int BUS_W = LANES * LANE_WIDTH;
    localparam int IDX_W = idx_width(LANES);

    logic                  enabler;
    logic                  write_scalar_reg_W;
    logic                  write_vector_reg_W;
    logic [1:0]            result_source_W;
    logic [ADDR_WIDTH-1:0] rd_W;
    logic [BUS_W-1:0]      ALU_result_bus_W;
    logic [BUS_W-1:0]      read_data_bus_W;
    logic [PC_WIDTH-1:0]   PC_plus_4_W;

    logic                  s_we;
    logic [ADDR_WIDTH-1:0] s_waddr;
    logic [LANE_WIDTH-1:0] s_wdata;
    logic                  v_we;
    logic [ADDR_WIDTH-1:0] v_waddr;
    logic [IDX_W-1:0]      v_lane;
    logic [LANE_WIDTH-1:0] v_wdata;
    logic                  stall_W;
`ifdef WB_FORWARD_EN
    logic                  fwd_valid;
    logic [ADDR_WIDTH-1:0] fwd_rd;
    logic [BUS_W-1:0]      fwd_data;
`endif

    modport slave (
        input  enabler, write_scalar_reg_W, write_vector_reg_W, result_source_W,
               rd_W, ALU_result_bus_W, read_data_bus_W, PC_plus_4_W,
`ifdef WB_FORWARD_EN
        output fwd_valid, fwd_rd, fwd_data,
`endif
        output s_we, s_waddr, s_wdata, v_we, v_waddr, v_lane, v_wdata, stall_W
    );

    modport master (
        output enabler, write_scalar_reg_W, write_vector_reg_W, result_source_W,
               rd_W, ALU_result_bus_W, read_data_bus_W, PC_plus_4_W,
`ifdef WB_FORWARD_EN
        input  fwd_valid, fwd_rd, fwd_data,
`endif
        input  s_we, s_waddr, s_wdata, v_we, v_waddr, v_lane, v_wdata, stall_W
    );
endinterface

// File: rtl/writeback_stage_vp_result_mux.sv
// Writeback result source select; PC+4 is zero-extended to the full vector width.
module wb_result_mux
    import vp_wb_pkg::*;
#(
    parameter int BUS_W = DEF_LANES * DEF_LANE_WIDTH
) (
    input  logic [1:0]          result_source,
    input  logic [BUS_W-1:0]    alu_result,
    input  logic [BUS_W-1:0]    read_data,
    input  logic [PC_WIDTH-1:0] pc_plus_4,
    output logic [BUS_W-1:0]    result
);
    // The reserved encoding falls through to the ALU bus.
    always_comb begin
        case (result_source)
            RS_MEM:  result = read_data;
            RS_PC4:  result = {{(BUS_W-PC_WIDTH){1'b0}}, pc_plus_4};
            default: result = alu_result;
        endcase
    end
endmodule

// File: rtl/writeback_stage_vp.sv
// Writeback stage: one-cycle scalar commit, LANES-beat serialized vector commit.
// Define WB_FORWARD_EN to present the committing result to the forwarding unit.
module writeback_stage_vp
    import vp_wb_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int LANE_WIDTH = DEF_LANE_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input logic               clock,
    input logic               async_reset,
    writeback_stage_vp_if.slave wb
);
    localparam int BUS_W = LANES * LANE_WIDTH;
    localparam int IDX_W = idx_width(LANES);

    wb_state_t             state_reg, state_next;
    logic [IDX_W-1:0]      count_reg, count_next;
    logic [BUS_W-1:0]      data_reg, data_next;
    logic [ADDR_WIDTH-1:0] rd_reg, rd_next;

    logic [BUS_W-1:0]      result;
    logic [LANE_WIDTH-1:0] live_lane [LANES];
    logic [LANE_WIDTH-1:0] held_lane [LANES];

    logic                  s_we, v_we, stall;
    logic [ADDR_WIDTH-1:0] v_waddr;
    logic [IDX_W-1:0]      v_lane;
    logic [LANE_WIDTH-1:0] v_wdata;
`ifdef WB_FORWARD_EN
    logic                  fwd_valid;
    logic [ADDR_WIDTH-1:0] fwd_rd;
    logic [BUS_W-1:0]      fwd_data;
`endif

    wb_result_mux #(.BUS_W(BUS_W)) u_result_mux (
        .result_source (wb.result_source_W),
        .alu_result    (wb.ALU_result_bus_W),
        .read_data     (wb.read_data_bus_W),
        .pc_plus_4     (wb.PC_plus_4_W),
        .result        (result)
    );

    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : g_lane
        assign live_lane[gi] = result[gi*LANE_WIDTH +: LANE_WIDTH];
        assign held_lane[gi] = data_reg[gi*LANE_WIDTH +: LANE_WIDTH];
    end

    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            data_reg  <= '0;
            rd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            data_reg  <= data_next;
            rd_reg    <= rd_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        data_next  = data_reg;
        rd_next    = rd_reg;
        s_we       = 1'b0;
        v_we       = 1'b0;
        v_waddr    = '0;
        v_lane     = '0;
        v_wdata    = '0;
        stall      = 1'b0;
`ifdef WB_FORWARD_EN
        fwd_valid  = 1'b0;
        fwd_rd     = '0;
        fwd_data   = '0;
`endif
        case (state_reg)
            IDLE: begin
                s_we = wb.enabler & wb.write_scalar_reg_W & (wb.rd_W != '0);
                if (wb.enabler && wb.write_vector_reg_W) begin
                    // Beat 0 leaves straight from the mux; the rest come from the latch.
                    v_we    = 1'b1;
                    v_waddr = wb.rd_W;
                    v_wdata = live_lane[0];
`ifdef WB_FORWARD_EN
                    fwd_valid = 1'b1;
                    fwd_rd    = wb.rd_W;
                    fwd_data  = result;
`endif
                    if (LANES > 1) begin
                        state_next = BURST;
                        count_next = IDX_W'(1);
                        data_next  = result;
                        rd_next    = wb.rd_W;
                        stall      = 1'b1;
                    end
                end
            end
            BURST: begin
                stall = 1'b1;
`ifdef WB_FORWARD_EN
                fwd_valid = 1'b1;
                fwd_rd    = rd_reg;
                fwd_data  = data_reg;
`endif
                if (wb.enabler) begin
                    v_we    = 1'b1;
                    v_waddr = rd_reg;
                    v_lane  = count_reg;
                    v_wdata = held_lane[count_reg];
                    // Releasing the stall on the last beat lets the pipe advance in the same cycle.
                    if (count_reg == IDX_W'(LANES - 1)) begin
                        stall      = 1'b0;
                        state_next = IDLE;
                        count_next = '0;
                    end else begin
                        count_next = count_reg + IDX_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign wb.s_we    = async_reset & s_we;
    assign wb.s_waddr = async_reset ? wb.rd_W : '0;
    assign wb.s_wdata = async_reset ? live_lane[0] : '0;
    assign wb.v_we    = async_reset & v_we;
    assign wb.v_waddr = async_reset ? v_waddr : '0;
    assign wb.v_lane  = async_reset ? v_lane : '0;
    assign wb.v_wdata = async_reset ? v_wdata : '0;
    assign wb.stall_W = async_reset & stall;
`ifdef WB_FORWARD_EN
    assign wb.fwd_valid = async_reset & fwd_valid;
    assign wb.fwd_rd    = async_reset ? fwd_rd : '0;
    assign wb.fwd_data  = async_reset ? fwd_data : '0;
`endif
endmodule

// File: tb/tb_writeback_stage_vp.sv
// Self-checking bench for writeback_stage_vp: vector table, directed bursts, random vs queue model.
module tb_writeback_stage_vp;
    localparam int LANES = 4;
    localparam int LW    = 32;
    localparam int AW    = 6;
    localparam logic [127:0] ALU_C = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] MEM_C = 128'hFEDCBA9876543210FEDCBA9876543210;

    logic clock = 1'b0;
    logic async_reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    writeback_stage_vp_if #(.LANES(LANES), .LANE_WIDTH(LW), .ADDR_WIDTH(AW)) wb ();

    writeback_stage_vp #(.LANES(LANES), .LANE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clock       (clock),
        .async_reset (async_reset),
        .wb          (wb.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         en;
        logic         ws;
        logic         wv;
        logic [1:0]   src;
        logic [5:0]   rd;
        logic [127:0] alu;
        logic [127:0] rdat;
        logic [31:0]  pc;
        logic         e_swe;
        logic [31:0]  e_swdata;
        logic         e_vwe;
        logic         e_stall;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic en, input logic ws, input logic wv, input logic [1:0] src,
                         input logic [5:0] rd, input logic [127:0] alu, input logic [127:0] rdat,
                         input logic [31:0] pc);
        wb.enabler            = en;
        wb.write_scalar_reg_W = ws;
        wb.write_vector_reg_W = wv;
        wb.result_source_W    = src;
        wb.rd_W               = rd;
        wb.ALU_result_bus_W   = alu;
        wb.read_data_bus_W    = rdat;
        wb.PC_plus_4_W        = pc;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 128'({wb.s_we, wb.s_waddr, wb.s_wdata, wb.v_we, wb.v_waddr, wb.v_lane,
                       wb.v_wdata, wb.stall_W}), 128'(0));
`ifdef WB_FORWARD_EN
        chk({tag, ".fwd"}, 128'({wb.fwd_valid, wb.fwd_rd}) | wb.fwd_data, 128'(0));
`endif
    endtask

    task automatic chk_beat(input string tag, input logic e_vwe, input logic [1:0] e_lane,
                            input logic [31:0] e_data, input logic [5:0] e_addr, input logic e_stall);
        chk({tag, ".v_we"}, 128'(wb.v_we), 128'(e_vwe));
        if (e_vwe) begin
            chk({tag, ".v_lane"}, 128'(wb.v_lane), 128'(e_lane));
            chk({tag, ".v_wdata"}, 128'(wb.v_wdata), 128'(e_data));
            chk({tag, ".v_waddr"}, 128'(wb.v_waddr), 128'(e_addr));
        end
        chk({tag, ".stall_W"}, 128'(wb.stall_W), 128'(e_stall));
    endtask

    // Reference model: a committing vector is a list of lanes still owed to the register file.
    logic [31:0]  pend_q[$];
    logic [5:0]   pend_rd;
    logic [127:0] pend_full;

    function automatic logic [127:0] ref_result(input logic [1:0] src, input logic [127:0] alu,
                                                input logic [127:0] rdat, input logic [31:0] pc);
        if (src == 2'd1) return rdat;
        if (src == 2'd2) return {96'd0, pc};
        return alu;
    endfunction

    initial begin
        logic [127:0] val;
        logic [127:0] res;
        logic         en, ws, wv, e_swe, e_vwe, e_stall, e_fv;
        logic [1:0]   src, e_lane;
        logic [5:0]   rd, e_addr;
        logic [31:0]  e_vd;
        int           txn;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 2'd0, 6'd5,  ALU_C, MEM_C, 32'h0,        1'b1, 32'h89ABCDEF, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 2'd2, 6'd0,  ALU_C, MEM_C, 32'h80000004, 1'b0, 32'h80000004, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 2'd2, 6'd7,  ALU_C, MEM_C, 32'h80000004, 1'b1, 32'h80000004, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 2'd1, 6'd9,  ALU_C, MEM_C, 32'h0,        1'b1, 32'h76543210, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 2'd3, 6'd63, ALU_C, MEM_C, 32'h11111111, 1'b1, 32'h89ABCDEF, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 2'd0, 6'd5,  ALU_C, MEM_C, 32'h0,        1'b0, 32'h89ABCDEF, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 2'd1, 6'd5,  ALU_C, MEM_C, 32'h0,        1'b0, 32'h76543210, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 2'd2, 6'd1,  ALU_C, MEM_C, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0};

        // Reset with a live vector request: outputs must still be forced to zero.
        drive(1'b1, 1'b1, 1'b1, 2'd0, 6'd5, ALU_C, MEM_C, 32'h4);
        tick();
        @(negedge clock);
        chk_zero("reset_state");
        drive(1'b0, 1'b0, 1'b0, 2'd0, 6'd0, '0, '0, '0);
        tick();
        async_reset = 1'b1;
        $display("seq reset_release");

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].en, tbl[i].ws, tbl[i].wv, tbl[i].src, tbl[i].rd, tbl[i].alu, tbl[i].rdat, tbl[i].pc);
            @(negedge clock);
            chk($sformatf("tbl%0d.s_we", i), 128'(wb.s_we), 128'(tbl[i].e_swe));
            chk($sformatf("tbl%0d.s_wdata", i), 128'(wb.s_wdata), 128'(tbl[i].e_swdata));
            chk($sformatf("tbl%0d.s_waddr", i), 128'(wb.s_waddr), 128'(tbl[i].rd));
            chk($sformatf("tbl%0d.v_we", i), 128'(wb.v_we), 128'(tbl[i].e_vwe));
            chk($sformatf("tbl%0d.stall_W", i), 128'(wb.stall_W), 128'(tbl[i].e_stall));
            $display("vec %0d en=%0b ws=%0b wv=%0b src=%0d rd=%0d", i, tbl[i].en, tbl[i].ws, tbl[i].wv, tbl[i].src, tbl[i].rd);
            tick();
        end

        // Vector memory write: four beats, stall released on the last one.
        val = MEM_C;
        drive(1'b1, 1'b0, 1'b1, 2'd1, 6'd26, '0, MEM_C, '0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clock);
            chk_beat($sformatf("vmem.b%0d", b), 1'b1, 2'(b), val[32*b +: 32], 6'd26, b != 3);
            tick();
        end
        wb.write_vector_reg_W = 1'b0;
        @(negedge clock);
        chk_beat("vmem.after", 1'b0, 2'd0, 32'd0, 6'd0, 1'b0);
        $display("seq vector_mem_write rd=26");
        tick();

        // Enabler gap after beat 1.
        val = ALU_C;
        drive(1'b1, 1'b0, 1'b1, 2'd0, 6'd12, ALU_C, '0, '0);
        for (int b = 0; b < 6; b++) begin
            wb.enabler = !(b == 2 || b == 3);
            @(negedge clock);
            if (b == 2 || b == 3)
                chk_beat($sformatf("gap.c%0d", b), 1'b0, 2'd0, 32'd0, 6'd0, 1'b1);
            else
                chk_beat($sformatf("gap.c%0d", b), 1'b1, 2'(b < 2 ? b : b - 2),
                         val[32*(b < 2 ? b : b - 2) +: 32], 6'd12, b != 5);
            tick();
        end
        wb.write_vector_reg_W = 1'b0;
        $display("seq enabler_gap rd=12");

        // Combined scalar + vector request.
        drive(1'b1, 1'b1, 1'b1, 2'd0, 6'd5, ALU_C, MEM_C, '0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clock);
            chk($sformatf("comb.b%0d.s_we", b), 128'(wb.s_we), 128'(b == 0));
            if (b == 0) chk("comb.s_wdata", 128'(wb.s_wdata), 128'(32'h89ABCDEF));
            chk_beat($sformatf("comb.b%0d", b), 1'b1, 2'(b), val[32*b +: 32], 6'd5, b != 3);
`ifdef WB_FORWARD_EN
            chk($sformatf("comb.b%0d.fwd_valid", b), 128'(wb.fwd_valid), 128'(1));
            chk($sformatf("comb.b%0d.fwd_data", b), wb.fwd_data, ALU_C);
            chk($sformatf("comb.b%0d.fwd_rd", b), 128'(wb.fwd_rd), 128'(5));
`endif
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 6'd0, '0, '0, '0);
        $display("seq combined_request rd=5");

        // Reset mid-burst while the lane counter is at 2.
        drive(1'b1, 1'b0, 1'b1, 2'd1, 6'd33, '0, MEM_C, '0);
        tick();
        tick();
        @(negedge clock);
        chk_beat("rstburst.pre", 1'b1, 2'd2, 32'h76543210, 6'd33, 1'b1);
        #2;
        async_reset = 1'b0;
        #1;
        chk_zero("rstburst.during");
        wb.write_vector_reg_W = 1'b0;
        tick();
        async_reset = 1'b1;
        @(negedge clock);
        chk_beat("rstburst.after", 1'b0, 2'd0, 32'd0, 6'd0, 1'b0);
        $display("seq reset_mid_burst");
        tick();

        // Randomized traffic against the lane-queue model.
        txn = 0;
        pend_q.delete();
        for (int c = 0; c < 800; c++) begin
            e_swe = 1'b0;
            e_vwe = 1'b0;
            e_lane = 2'd0;
            e_vd = '0;
            e_addr = '0;
            e_fv = 1'b0;
            if (pend_q.size() == 0) begin
                en  = ($urandom_range(0, 3) != 0);
                ws  = 1'($urandom_range(0, 1));
                wv  = 1'($urandom_range(0, 1));
                src = 2'($urandom_range(0, 3));
                rd  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
                drive(en, ws, wv, src, rd, {$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom}, $urandom);
                res = ref_result(src, wb.ALU_result_bus_W, wb.read_data_bus_W, wb.PC_plus_4_W);
                e_swe = en & ws & (rd != 6'd0);
                if (en && wv) begin
                    e_vwe = 1'b1;
                    e_vd = res[31:0];
                    e_addr = rd;
                    e_fv = 1'b1;
                    for (int l = 1; l < LANES; l++) pend_q.push_back(res[32*l +: 32]);
                    pend_rd = rd;
                    pend_full = res;
                end
                if (en) begin
                    txn++;
                    $display("txn %0d ws=%0b wv=%0b src=%0d rd=%0d", txn, ws, wv, src, rd);
                end
                e_stall = (pend_q.size() != 0);
                @(negedge clock);
                chk($sformatf("rnd%0d.s_wdata", c), 128'(wb.s_wdata), 128'(res[31:0]));
            end else begin
                en = ($urandom_range(0, 2) != 0);
                wb.enabler = en;
                e_fv = 1'b1;
                e_stall = 1'b1;
                if (en) begin
                    e_vwe = 1'b1;
                    e_lane = 2'(LANES - pend_q.size());
                    e_vd = pend_q.pop_front();
                    e_addr = pend_rd;
                    e_stall = (pend_q.size() != 0);
                end
                @(negedge clock);
            end
            chk($sformatf("rnd%0d.s_we", c), 128'(wb.s_we), 128'(e_swe));
            if (e_swe) chk($sformatf("rnd%0d.s_waddr", c), 128'(wb.s_waddr), 128'(wb.rd_W));
            chk_beat($sformatf("rnd%0d", c), e_vwe, e_lane, e_vd, e_addr, e_stall);
`ifdef WB_FORWARD_EN
            chk($sformatf("rnd%0d.fwd_valid", c), 128'(wb.fwd_valid), 128'(e_fv));
            if (e_fv) chk($sformatf("rnd%0d.fwd_data", c), wb.fwd_data, pend_full);
`else
            if (e_fv) chk($sformatf("rnd%0d.burst_addr", c), 128'(pend_rd), 128'(wb.v_we ? wb.v_waddr : pend_rd));
`endif
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end
endmodule
